bus_access_mux: RTL

- Downstream consumer of the 16-cycle bus timing windows (pi_select/pi_strobe, cpu_select/io_select/cpu_strobe).
- Arbitrates the shared SRAM bus between the Raspberry Pi bridge (SPI command decoder) and the 6502.
- Drives RAM address, data, OE and WE, and IO chip-select during the appropriate window.
- Returns read data and completion pulses to each master.

---
 rtl/bus_access_mux.sv | 118 +++++++++++
 1 files changed

// File: rtl/bus_access_mux.sv
// Shared SRAM bus arbiter between the Pi bridge and the 6502, keyed off the 16-cycle frame windows.
// Bus pins are decoded from the registered window strobes, so they move on the same edge as the windows.
module bus_access_mux #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [15:0] IO_BASE    = 16'hE800,
  parameter logic [15:0] IO_MASK    = 16'hF800
) (
  input  logic                  clk16,
  input  logic                  reset,
  input  logic                  pi_select,
  input  logic                  pi_strobe,
  input  logic                  cpu_select,
  input  logic                  io_select,
  input  logic                  cpu_strobe,
  input  logic                  pi_start,
  input  logic                  pi_we,
  input  logic [ADDR_WIDTH-1:0] pi_addr,
  input  logic [7:0]            pi_wdata,
  output logic                  pi_busy,
  output logic                  pi_done,
  output logic [7:0]            pi_rdata,
  output logic                  pi_overrun,
  input  logic [15:0]           cpu_addr,
  input  logic                  cpu_we,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_done,
  output logic                  io_cs,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic                  ram_oe,
  output logic                  ram_we
);

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE, DONE} state_t;

  state_t                state;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_wdata;
  logic                  cpu_win_q;

  logic cpu_io, cpu_win, pi_bus;

  assign cpu_io  = (cpu_addr & IO_MASK) == IO_BASE;
  // Pi owns any overlapping window; the CPU is simply not served that cycle.
  assign cpu_win = cpu_select & ~pi_select;
  assign pi_bus  = pi_select & (((state == PENDING) & pi_strobe) | (state == ACTIVE));

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      pi_busy    <= 1'b0;
      pi_done    <= 1'b0;
      pi_rdata   <= '0;
      pi_overrun <= 1'b0;
      cpu_rdata  <= '0;
      cpu_win_q  <= 1'b0;
    end else begin
      pi_done <= 1'b0;
      if (pi_start && state != IDLE) pi_overrun <= 1'b1;
      case (state)
        IDLE: if (pi_start) begin
          req_we    <= pi_we;
          req_addr  <= pi_addr;
          req_wdata <= pi_wdata;
          pi_busy   <= 1'b1;
          state     <= PENDING;
        end
        PENDING: if (pi_select && pi_strobe) state <= ACTIVE;
        ACTIVE: begin
          if (!req_we) pi_rdata <= ram_rdata;
          pi_busy <= 1'b0;
          pi_done <= 1'b1;
          state   <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      cpu_win_q <= cpu_win;
      // Address is stable across the window, so the final capture is the last-cycle value.
      if (cpu_win && !cpu_io && !cpu_we) cpu_rdata <= ram_rdata;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_oe    = 1'b0;
    ram_we    = 1'b0;
    io_cs     = 1'b0;
    if (!reset) begin
      if (pi_select) begin
        if (pi_bus) begin
          ram_addr  = req_addr;
          ram_wdata = req_wdata;
          ram_oe    = ~req_we;
          ram_we    = req_we & (state == PENDING);
        end
      end else if (cpu_select) begin
        ram_addr  = {{(ADDR_WIDTH-16){1'b0}}, cpu_addr};
        ram_wdata = cpu_wdata;
        if (cpu_io) io_cs = io_select;
        else begin
          ram_oe = ~cpu_we;
          ram_we = cpu_we & cpu_strobe;
        end
      end
    end
  end

  assign cpu_done = ~reset & cpu_win_q & ~cpu_select;

endmodule
